// File: rtl/pulse_link_arbiter.sv
// Round-robin arbiter that shares one single-wire pulse link between N_REQ requesters.
// Each grant is sent as a framed burst: start pulse, ID bits MSB first, then a low guard gap.
module pulse_link_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int PULSE_LEN = 8,
  parameter int GAP_LEN   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id,
  output logic             link_out
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam int SLOT_W  = $clog2(ID_W) + 1;

  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(ID_W - 1);
  localparam logic [ID_W-1:0]   LAST_INIT  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BITS  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [SLOT_W-1:0]  slot_r, slot_s;
  logic [N_REQ-1:0]   pending_r, pending_s;
  logic [N_REQ-1:0]   clr_s;
  logic [ID_W-1:0]    last_r, last_s;
  logic [ID_W-1:0]    grant_r, grant_s;
  logic [ID_W-1:0]    pick_s;
  logic [N_REQ-1:0]   ack_r, ack_s;
  logic               busy_r;
  logic               link_r, link_s;

  // Scanning downward lets the last assignment win, i.e. the first set bit after 'last'.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] sel;
    sel = {ID_W{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        sel = ((((int'(last) + k) % N_REQ) == i) && pend[i]) ? ID_W'(i) : sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] g);
    logic [N_REQ-1:0] v;
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = (g == ID_W'(i));
    end
    return v;
  endfunction

  function automatic logic id_bit(input logic [ID_W-1:0] g, input logic [SLOT_W-1:0] slot);
    logic b;
    b = 1'b0;
    for (int i = 0; i < ID_W; i++) begin
      b = (slot == SLOT_W'(i)) ? g[ID_W-1-i] : b;
    end
    return b;
  endfunction

  // Next-state, counter, grant and pending-vector logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    slot_s  = slot_r;
    last_s  = last_r;
    grant_s = grant_r;
    clr_s   = {N_REQ{1'b0}};
    pick_s  = rr_pick(pending_r, last_r);
    case (state_r)
      IDLE: begin
        if (pending_r != {N_REQ{1'b0}}) begin
          state_s = START;
          cnt_s   = {CNT_W{1'b0}};
          slot_s  = {SLOT_W{1'b0}};
          grant_s = pick_s;
          last_s  = pick_s;
          clr_s   = onehot(pick_s);
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == PULSE_LAST) begin
          state_s = BITS;
          cnt_s   = {CNT_W{1'b0}};
          slot_s  = {SLOT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      BITS: begin
        if (cnt_r == PULSE_LAST) begin
          cnt_s = {CNT_W{1'b0}};
          if (slot_r == SLOT_LAST) begin
            state_s = GAP;
            slot_s  = {SLOT_W{1'b0}};
          end else begin
            slot_s = slot_r + SLOT_W'(1);
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        slot_s  = {SLOT_W{1'b0}};
      end
    endcase
    // A request arriving in the grant cycle keeps its pending bit set.
    pending_s = (pending_r & ~clr_s) | req;
  end

  // Output values for the next cycle, derived from the next state so outputs are registered.
  always_comb begin
    link_s = 1'b0;
    ack_s  = {N_REQ{1'b0}};
    case (state_s)
      START: begin
        link_s = 1'b1;
      end
      BITS: begin
        link_s = id_bit(grant_s, slot_s);
      end
      GAP: begin
        if (cnt_s == GAP_LAST) begin
          ack_s = onehot(grant_s);
        end else begin
          ack_s = {N_REQ{1'b0}};
        end
      end
      default: begin
        link_s = 1'b0;
      end
    endcase
  end

  // State, counters, pending vector and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      slot_r    <= {SLOT_W{1'b0}};
      pending_r <= {N_REQ{1'b0}};
      last_r    <= LAST_INIT;
      grant_r   <= {ID_W{1'b0}};
      ack_r     <= {N_REQ{1'b0}};
      busy_r    <= 1'b0;
      link_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      slot_r    <= slot_s;
      pending_r <= pending_s;
      last_r    <= last_s;
      grant_r   <= grant_s;
      ack_r     <= ack_s;
      busy_r    <= (state_s != IDLE);
      link_r    <= link_s;
    end
  end

  assign ack      = ack_r;
  assign busy     = busy_r;
  assign grant_id = grant_r;
  assign link_out = link_r;

endmodule

// File: tb/tb_pulse_link_arbiter.sv
// Scoreboard bench for pulse_link_arbiter: directed stimulus pushes expected frames,
// a monitor checks every cycle of link_out/busy/grant_id/ack against them.
module tb_pulse_link_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int PL    = 8;
  localparam int GL    = 8;
  localparam int F     = PL * (1 + ID_W) + GL;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic             busy;
  logic [ID_W-1:0]  grant_id;
  logic             link_out;

  pulse_link_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .PULSE_LEN(PL), .GAP_LEN(GL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .busy(busy), .grant_id(grant_id), .link_out(link_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int start;
    int abort_at;
  } frame_t;

  frame_t sb_q[$];
  frame_t cur;
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  bit     in_frame = 1'b0;
  int     fcyc = 0;
  int     t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference frame shape: start pulse, ID MSB first, then gap.
  function automatic int exp_link(input int id, input int f);
    int slot;
    if (f < PL) return 1;
    if (f < PL * (1 + ID_W)) begin
      slot = (f - PL) / PL;
      return (id >> (ID_W - 1 - slot)) & 1;
    end
    return 0;
  endfunction

  // Monitor: pops an expected frame when busy rises and checks every cycle.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (!in_frame && busy === 1'b1 && sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        in_frame = 1'b1;
        fcyc = 0;
        check("frame_start", cyc, cur.start);
      end
      if (in_frame) begin
        if (cur.abort_at >= 0 && fcyc == cur.abort_at) begin
          check("abort_busy", busy, 0);
          check("abort_link", link_out, 0);
          check("abort_ack", ack, 0);
          in_frame = 1'b0;
        end else begin
          check("frame_busy", busy, 1);
          check("frame_grant", grant_id, cur.id);
          check("frame_link", link_out, exp_link(cur.id, fcyc));
          check("frame_ack", ack, (fcyc == F - 1) ? (1 << cur.id) : 0);
          fcyc++;
          if (fcyc == F) in_frame = 1'b0;
        end
      end else begin
        check("idle_busy", busy, 0);
        check("idle_link", link_out, 0);
        check("idle_ack", ack, 0);
      end
    end
  end

  task automatic at(input int k);
    while (cyc < t0 + k) @(negedge clk);
  endtask

  task automatic begin_test();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic push(input int id, input int k, input int abort_at);
    frame_t e;
    e.id = id;
    e.start = t0 + k;
    e.abort_at = abort_at;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || in_frame) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size() + int'(in_frame), 0);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check("rst_link", link_out, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single request from requester 2.
    begin_test();
    push(2, 2, -1);
    req = 4'b0100;
    at(1); req = 4'b0000;
    drain();

    // All four at once: served 0,1,2,3 with period F+1.
    begin_test();
    push(0, 2, -1); push(1, 35, -1); push(2, 68, -1); push(3, 101, -1);
    req = 4'b1111;
    at(1); req = 4'b0000;
    drain();

    // Requesters 0 and 3 held: alternate; 0 still pending after release gets one more frame.
    begin_test();
    push(0, 2, -1); push(3, 35, -1); push(0, 68, -1); push(3, 101, -1); push(0, 134, -1);
    req = 4'b1001;
    at(100); req = 4'b0000;
    drain();

    // Requester 3: all-ones frame.
    begin_test();
    push(3, 2, -1);
    req = 4'b1000;
    at(1); req = 4'b0000;
    drain();

    // Repeated requests from 1 during a frame merge into one.
    begin_test();
    push(0, 2, -1); push(1, 35, -1);
    req = 4'b0001;
    at(1);  req = 4'b0000;
    at(5);  req = 4'b0010;
    at(6);  req = 4'b0000;
    at(10); req = 4'b0010;
    at(11); req = 4'b0000;
    at(20); req = 4'b0010;
    at(21); req = 4'b0000;
    drain();

    // Reset mid-frame aborts it: no ack, no retry.
    begin_test();
    push(1, 2, 14);
    req = 4'b0010;
    at(1);  req = 4'b0000;
    at(15); rst = 1'b1;
    at(16); rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_link_arbiter.md
Name: pulse_link_arbiter

Overview:
- Shares one single-wire pulse link between N_REQ local requesters.
- Each request is latched and granted round-robin. The winner's ID goes out as one framed pulse burst: a start pulse, then ID bits (MSB first), each PULSE_LEN cycles wide, then a low guard gap.
- The block sits in front of the board-to-board link output and replaces per-source pulse stretchers when several event sources share one wire.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, ID bits per frame; must be >= clog2(N_REQ).
- PULSE_LEN, 8, cycles per start pulse and per ID bit (>= 2).
- GAP_LEN, 8, low guard cycles after the ID bits (>= 1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- req  input  N_REQ  per-requester request; level or single-cycle pulse, sampled every clk.
- ack  output  N_REQ  one-cycle pulse when the frame for that requester completes.
- busy  output  1  high while a frame is in progress (state != IDLE).
- grant_id  output  ID_W  ID of the requester being sent; valid while busy.
- link_out  output  1  serial link line; a function of registered state only.

Behaviour:
- Reset values: link_out=0, ack=0, busy=0, grant_id=0. Reset also clears the pending vector and the bit/cycle counters, and sets last_grant=N_REQ-1, so requester 0 has top priority after reset.
- Request latching:
  - pending[i] is set on the clk after req[i]=1.
  - Repeated requests while pending[i]=1 merge; there is no request counting.
- States: IDLE, START, BITS, GAP.
- IDLE:
  - If pending != 0, select the first set bit scanning from last_grant+1 upward with wrap at N_REQ.
  - Register grant_id and update last_grant to the selected index.
  - Clear that pending bit. If req of the same index is high in that cycle, the set wins and the bit stays pending.
  - Go to START with the cycle counter at 0.
  - With pending=0, stay in IDLE.
- START: link_out=1 for PULSE_LEN cycles, then go to BITS.
- BITS:
  - Runs ID_W slots of PULSE_LEN cycles each.
  - link_out equals grant_id bit (ID_W-1-slot), MSB first.
  - After the last slot, go to GAP.
- GAP:
  - link_out=0 for GAP_LEN cycles.
  - On the last GAP cycle, ack[grant_id]=1 for exactly that cycle.
  - Then go to IDLE.
- Timing:
  - req sampled at cycle t → pending at t+1 → START occupies cycles t+2..t+1+PULSE_LEN.
  - Frame length F = PULSE_LEN*(1+ID_W)+GAP_LEN.
  - At least one IDLE cycle separates frames, so the back-to-back frame period is F+1.
- Counters: cycle counter width clog2(PULSE_LEN max GAP_LEN)+1; it resets to 0 on every state change. Bit-slot counter width clog2(ID_W)+1.
- Requests for the requester currently being sent re-set its pending bit and produce a later frame. There is no preemption; a frame always completes unless rst is asserted.
- Reset mid-frame:
  - On the next clk, link_out=0, busy=0, state=IDLE, pending cleared.
  - The ack for the aborted frame is never issued.
  - After reset there is no automatic retry.
- At most one ack bit is high in any cycle.
- busy is high exactly from the first START cycle through the last GAP cycle.

Test Plan:
- Defaults (N_REQ=4, ID_W=2, PULSE_LEN=8, GAP_LEN=8); req[2] pulsed at cycle 0 → link_out high 2–9 (start), high 10–17 (bit1=1), low 18–25 (bit0=0), low 26–33 (gap). ack[2] high only at cycle 33; busy high 2–33; grant_id=2.
- req=4'b1111 pulsed at cycle 0 → frames in order 0,1,2,3 starting at cycles 2, 35, 68, 101; acks at 33, 66, 99, 132; no fifth frame.
- req[0] and req[3] held high continuously → grant order 0,3,0,3,…; each requester gets every other frame and no frame is ever idle-starved.
- req[3] pulsed once → link_out high continuously for cycles 2–25 (24 cycles), low 26–33, ack[3] at 33.
- During a frame for requester 0, pulse req[1] three times → exactly one following frame for requester 1 and one ack[1].
- req[1] at cycle 0; rst high at cycle 15 for one cycle → link_out=0 and busy=0 from cycle 16; no ack[1] ever; link stays idle until a new req.
